// File: rtl/multicycle_datapath_regs.sv
// multicycle_datapath_regs: PC/OldPC/IR/MDR/A/B/ALUOut state, address and result muxes, fetch counter
module multicycle_datapath_regs #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h00400000,
  parameter logic [DATA_WIDTH-1:0] RESET_INSTR = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCWrite,
  input  logic                  Branch,
  input  logic                  AdrSrc,
  input  logic                  IRWrite,
  input  logic [1:0]            ResultSrc,
  input  logic [DATA_WIDTH-1:0] ReadData,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] RD1,
  input  logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] OldPC,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] Data,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ALUOut,
  output logic [DATA_WIDTH-1:0] Adr,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  PCEn,
  output logic [31:0]           InstrCount
);
  logic [DATA_WIDTH-1:0] pc_q, pc_d, old_pc_q, old_pc_d, instr_q, instr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, a_q, a_d, wd_q, wd_d, alu_out_q, alu_out_d;
  logic [31:0]           instr_count_q, instr_count_d;
  // case default keeps X/Z selects on ALUOut
  always_comb begin
    Result = alu_out_q;
    case (ResultSrc)
      2'b01:   Result = data_q;
      2'b10:   Result = ALUResult;
      default: Result = alu_out_q;
    endcase
  end
  always_comb begin
    PCEn          = PCWrite | Branch;
    Adr           = AdrSrc ? Result : pc_q;
    pc_d          = PCEn ? Result : pc_q;
    instr_d       = IRWrite ? ReadData : instr_q;
    old_pc_d      = IRWrite ? pc_q : old_pc_q;
    instr_count_d = IRWrite ? instr_count_q + 32'd1 : instr_count_q;
    data_d        = ReadData;
    a_d           = RD1;
    wd_d          = RD2;
    alu_out_d     = ALUResult;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      old_pc_q      <= RESET_PC;
      instr_q       <= RESET_INSTR;
      data_q        <= '0;
      a_q           <= '0;
      wd_q          <= '0;
      alu_out_q     <= '0;
      instr_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      old_pc_q      <= old_pc_d;
      instr_q       <= instr_d;
      data_q        <= data_d;
      a_q           <= a_d;
      wd_q          <= wd_d;
      alu_out_q     <= alu_out_d;
      instr_count_q <= instr_count_d;
    end
  end
  assign PC         = pc_q;
  assign OldPC      = old_pc_q;
  assign Instr      = instr_q;
  assign Data       = data_q;
  assign A          = a_q;
  assign WriteData  = wd_q;
  assign ALUOut     = alu_out_q;
  assign InstrCount = instr_count_q;
endmodule

// File: tb/tb_multicycle_datapath_regs.sv
// tb_multicycle_datapath_regs: directed table, corner sequences and random run against a reference model
module tb_multicycle_datapath_regs;
  logic        clk = 1'b0;
  logic        rst, pcw, br, asrc, irw;
  logic [1:0]  rsrc;
  logic [31:0] rd, alur, rd1, rd2;
  logic [31:0] pc, old_pc, instr, data, a, wd, alu_out, adr, result, cnt;
  logic        pcen;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc, m_old, m_ir, m_data, m_a, m_b, m_alu, m_cnt;

  always #5 clk = ~clk;

  multicycle_datapath_regs dut (
    .clk(clk), .rst(rst), .PCWrite(pcw), .Branch(br), .AdrSrc(asrc), .IRWrite(irw),
    .ResultSrc(rsrc), .ReadData(rd), .ALUResult(alur), .RD1(rd1), .RD2(rd2),
    .PC(pc), .OldPC(old_pc), .Instr(instr), .Data(data), .A(a), .WriteData(wd),
    .ALUOut(alu_out), .Adr(adr), .Result(result), .PCEn(pcen), .InstrCount(cnt)
  );

  typedef struct {
    logic        pcw, br, asrc, irw;
    logic [1:0]  rsrc;
    logic [31:0] rd, alur;
    logic [31:0] e_result, e_adr;
    logic        e_pcen;
    logic [31:0] e_pc, e_instr, e_old, e_cnt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_result();
    return (rsrc == 2'd1) ? m_data : (rsrc == 2'd2) ? alur : m_alu;
  endfunction

  task automatic model_reset();
    m_pc = 32'h00400000; m_old = 32'h00400000; m_ir = 32'h00000013;
    m_data = 0; m_a = 0; m_b = 0; m_alu = 0; m_cnt = 0;
  endtask

  task automatic check_state();
    chk("pc", pc, m_pc);
    chk("old_pc", old_pc, m_old);
    chk("instr", instr, m_ir);
    chk("data", data, m_data);
    chk("a", a, m_a);
    chk("write_data", wd, m_b);
    chk("alu_out", alu_out, m_alu);
    chk("instr_count", cnt, m_cnt);
  endtask

  task automatic check_comb();
    logic [31:0] r;
    r = exp_result();
    chk("result", result, r);
    chk("adr", adr, asrc ? r : m_pc);
    chk("pcen", {31'd0, pcen}, {31'd0, pcw | br});
  endtask

  task automatic step();
    logic [31:0] r, pc0;
    #1;
    check_comb();
    r = exp_result();
    pc0 = m_pc;
    @(posedge clk);
    #1;
    if (pcw || br) m_pc = r;
    if (irw) begin
      m_ir = rd;
      m_old = pc0;
      m_cnt = m_cnt + 1;
    end
    m_data = rd; m_a = rd1; m_b = rd2; m_alu = alur;
    check_state();
  endtask

  initial begin
    tbl[0] = '{1,0,0,1,2'b10,32'h00500093,32'h00400004, 32'h00400004,32'h00400000,1, 32'h00400004,32'h00500093,32'h00400000,1};
    tbl[1] = '{0,0,0,0,2'b00,32'h0,32'h10010000,        32'h00400004,32'h00400004,0, 32'h00400004,32'h00500093,32'h00400000,1};
    tbl[2] = '{0,0,1,0,2'b00,32'hCAFEBABE,32'h0,        32'h10010000,32'h10010000,0, 32'h00400004,32'h00500093,32'h00400000,1};
    tbl[3] = '{0,0,0,0,2'b01,32'h0,32'h0,               32'hCAFEBABE,32'h00400004,0, 32'h00400004,32'h00500093,32'h00400000,1};
    tbl[4] = '{0,0,0,0,2'b10,32'h0,32'h00400020,        32'h00400020,32'h00400004,0, 32'h00400004,32'h00500093,32'h00400000,1};
    tbl[5] = '{0,1,0,0,2'b10,32'h0,32'h00400020,        32'h00400020,32'h00400004,1, 32'h00400020,32'h00500093,32'h00400000,1};
    tbl[6] = '{1,1,0,1,2'b10,32'h11111111,32'h00400024, 32'h00400024,32'h00400020,1, 32'h00400024,32'h11111111,32'h00400020,2};
    tbl[7] = '{0,0,0,0,2'b11,32'h0,32'h0,               32'h00400024,32'h00400024,0, 32'h00400024,32'h11111111,32'h00400020,2};
    rst = 0; pcw = 0; br = 0; asrc = 0; irw = 0; rsrc = 0;
    rd = 0; alur = 0; rd1 = 0; rd2 = 0;
    model_reset();
    #12;
    check_state();
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      pcw = tbl[i].pcw; br = tbl[i].br; asrc = tbl[i].asrc; irw = tbl[i].irw;
      rsrc = tbl[i].rsrc; rd = tbl[i].rd; alur = tbl[i].alur; rd1 = 32'h0; rd2 = 32'h0;
      #1;
      chk($sformatf("tbl%0d_result", i), result, tbl[i].e_result);
      chk($sformatf("tbl%0d_adr", i), adr, tbl[i].e_adr);
      chk($sformatf("tbl%0d_pcen", i), {31'd0, pcen}, {31'd0, tbl[i].e_pcen});
      step();
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d_old_pc", i), old_pc, tbl[i].e_old);
      chk($sformatf("tbl%0d_count", i), cnt, tbl[i].e_cnt);
    end
    // unknown select must fall back to ALUOut
    pcw = 0; br = 0; irw = 0; asrc = 1; rsrc = 2'bxx; alur = 32'h12345678;
    #1;
    chk("mux_x_result", result, m_alu);
    chk("mux_x_adr", adr, m_alu);
    rsrc = 2'b11;
    step();
    for (int i = 0; i < 300; i++) begin
      pcw = ($urandom_range(0, 3) == 0); br = ($urandom_range(0, 4) == 0);
      irw = ($urandom_range(0, 3) == 0); asrc = $urandom_range(0, 1);
      rsrc = 2'($urandom_range(0, 3));
      rd = $urandom; alur = $urandom; rd1 = $urandom; rd2 = $urandom;
      step();
    end
    // asynchronous reset in the middle of a PC-writing cycle
    pcw = 1; irw = 1; rsrc = 2'b10; alur = 32'hDEADBEE0;
    #2;
    rst = 0;
    #1;
    model_reset();
    chk("rst_pc", pc, 32'h00400000);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_count", cnt, 32'h0);
    check_state();
    #2;
    rst = 1;
    pcw = 0; irw = 0;
    step();
    force dut.instr_count_q = 32'hFFFFFFFF;
    #1;
    release dut.instr_count_q;
    m_cnt = 32'hFFFFFFFF;
    irw = 1; rd = 32'h00A00113;
    step();
    chk("count_wrap", cnt, 32'h0);
    irw = 0;
    step();
    chk("count_hold", cnt, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
